// File: rtl/lane_obj_gen.sv
// lane_obj_gen: generator for N horizontal lanes of scrolling objects (cars, logs).
// Each lane keeps an offset that advances once per frame on refresh_tick and wraps
// modulo the object period. Per pixel it reports whether the pixel lies on an
// object, plus the sprite ROM row/col. The result is registered to line up with a
// 1-cycle sprite ROM. It also latches a per-frame frog/object overlap flag.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   x, y                current pixel from the vga controller
//   refresh_tick        1-clk pulse per frame
//   run                 1: lanes advance on refresh_tick, 0: frozen
//   lane_speed          3 bits per lane, px/frame
//   lane_dir            1 bit per lane, 0 = right, 1 = left
//   x_frog_l, y_frog_t  frog box top-left corner
//   obj_on              pixel (1 clk earlier) lies on an object
//   obj_lane/col/row    lane index, sprite column and row of that pixel (0 when off)
//   hit                 frog overlapped an object during the previous frame
//
// Optional feature, enabled by defining LANE_CARRY_EN:
//   carry_valid, carry_dx  the frog centre pixel was on an object last frame, and
//                          the signed per-frame drift of that lane.
module lane_obj_gen #(
    parameter int N_LANES    = 5,
    parameter int LANE_H     = 32,
    parameter int Y_BASE     = 260,
    parameter int P_LOG2     = 7,
    parameter int OBJ_W      = 64,
    parameter int PHASE_STEP = 32,
    parameter int FROG_SIZE  = 28
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [9:0]             x,
    input  logic [9:0]             y,
    input  logic                   refresh_tick,
    input  logic                   run,
    input  logic [3*N_LANES-1:0]   lane_speed,
    input  logic [N_LANES-1:0]     lane_dir,
    input  logic [9:0]             x_frog_l,
    input  logic [9:0]             y_frog_t,
    output logic                   obj_on,
    output logic [2:0]             obj_lane,
    output logic [P_LOG2-1:0]      obj_col,
    output logic [4:0]             obj_row,
    output logic                   hit
`ifdef LANE_CARRY_EN
    ,
    output logic                   carry_valid,
    output logic signed [3:0]      carry_dx
`endif
);

    localparam int LH_LOG2 = $clog2(LANE_H);
    localparam logic [10:0] Y_LO     = 11'(Y_BASE);
    localparam logic [10:0] Y_HI     = 11'(Y_BASE + N_LANES * LANE_H);
    localparam logic [10:0] ROW_MASK = 11'(LANE_H - 1);
    localparam logic [10:0] FROG_EXT = 11'(FROG_SIZE - 1);
    localparam logic [P_LOG2-1:0] OBJ_W_L = P_LOG2'(OBJ_W);

    function automatic logic [P_LOG2-1:0] reset_off(input int l);
        return P_LOG2'((l * PHASE_STEP) % (1 << P_LOG2));
    endfunction

    logic [P_LOG2-1:0] off [N_LANES];

    // Stage p0: lane decode, phase and collision term (combinational)
    logic [10:0]       dy_p0;
    logic              lane_ok_p0;
    logic [2:0]        lane_p0;
    logic [4:0]        row_p0;
    logic [P_LOG2-1:0] off_sel_p0;
    logic [P_LOG2-1:0] ph_p0;
    logic              vld_p0;
    logic              frog_px_p0;
    logic              hit_term_p0;
    logic [10:0]       fx_hi, fy_hi;

    assign dy_p0      = {1'b0, y} - Y_LO;
    assign lane_ok_p0 = ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);
    assign lane_p0    = 3'(dy_p0 >> LH_LOG2);
    assign row_p0     = 5'(dy_p0 & ROW_MASK);

    always_comb begin
        off_sel_p0 = '0;
        for (int l = 0; l < N_LANES; l++) begin
            if (lane_p0 == 3'(l)) off_sel_p0 = off[l];
        end
    end

    // Modulo-P subtraction makes objects straddling the screen edges wrap seamlessly.
    assign ph_p0  = x[P_LOG2-1:0] - off_sel_p0;
    assign vld_p0 = lane_ok_p0 && (x < 10'd640) && (ph_p0 < OBJ_W_L);

    assign fx_hi       = {1'b0, x_frog_l} + FROG_EXT;
    assign fy_hi       = {1'b0, y_frog_t} + FROG_EXT;
    assign frog_px_p0  = (x >= x_frog_l) && ({1'b0, x} <= fx_hi) &&
                         (y >= y_frog_t) && ({1'b0, y} <= fy_hi);
    assign hit_term_p0 = frog_px_p0 && vld_p0;

    // Per-lane offsets; the pixel path on a tick clock still sees the old offset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int l = 0; l < N_LANES; l++) off[l] <= reset_off(l);
        end else if (refresh_tick && run) begin
            for (int l = 0; l < N_LANES; l++) begin
                if (lane_dir[l]) off[l] <= off[l] - P_LOG2'(lane_speed[3*l +: 3]);
                else             off[l] <= off[l] + P_LOG2'(lane_speed[3*l +: 3]);
            end
        end
    end

    // Stage p1: registered pixel result, aligned with sprite ROM latency
    logic              vld_p1;
    logic [2:0]        lane_p1;
    logic [P_LOG2-1:0] col_p1;
    logic [4:0]        row_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            lane_p1 <= '0;
            col_p1  <= '0;
            row_p1  <= '0;
        end else begin
            vld_p1  <= vld_p0;
            lane_p1 <= vld_p0 ? lane_p0 : 3'd0;
            col_p1  <= vld_p0 ? ph_p0   : '0;
            row_p1  <= vld_p0 ? row_p0  : 5'd0;
        end
    end

    assign obj_on   = vld_p1;
    assign obj_lane = lane_p1;
    assign obj_col  = col_p1;
    assign obj_row  = row_p1;

    // Collision accumulator; on a tick the clear wins but the same-clock term is kept.
    logic hit_acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_acc <= 1'b0;
            hit     <= 1'b0;
        end else if (refresh_tick) begin
            hit     <= hit_acc | hit_term_p0;
            hit_acc <= 1'b0;
        end else if (hit_term_p0) begin
            hit_acc <= 1'b1;
        end
    end

`ifdef LANE_CARRY_EN
    // Track which lane (if any) held the frog centre pixel during the frame.
    logic [10:0]      cx, cy;
    logic             ctr_now;
    logic             ctr_acc;
    logic [2:0]       ctr_lane_acc;
    logic [2:0]       ctr_lane;
    logic             ctr_any;
    logic [2:0]       c_spd;
    logic             c_dir;
    logic signed [3:0] c_spd_s;

    assign cx      = {1'b0, x_frog_l} + 11'(FROG_SIZE / 2);
    assign cy      = {1'b0, y_frog_t} + 11'(FROG_SIZE / 2);
    assign ctr_now = vld_p0 && ({1'b0, x} == cx) && ({1'b0, y} == cy);
    assign ctr_any = ctr_acc | ctr_now;
    assign ctr_lane = ctr_now ? lane_p0 : ctr_lane_acc;

    always_comb begin
        c_spd = 3'd0;
        c_dir = 1'b0;
        for (int l = 0; l < N_LANES; l++) begin
            if (ctr_lane == 3'(l)) begin
                c_spd = lane_speed[3*l +: 3];
                c_dir = lane_dir[l];
            end
        end
    end

    assign c_spd_s = signed'({1'b0, c_spd});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctr_acc      <= 1'b0;
            ctr_lane_acc <= '0;
            carry_valid  <= 1'b0;
            carry_dx     <= '0;
        end else if (refresh_tick) begin
            carry_valid  <= ctr_any;
            carry_dx     <= !ctr_any ? 4'sd0 : (c_dir ? -c_spd_s : c_spd_s);
            ctr_acc      <= 1'b0;
            ctr_lane_acc <= '0;
        end else if (ctr_now) begin
            ctr_acc      <= 1'b1;
            ctr_lane_acc <= lane_p0;
        end
    end
`endif

endmodule

// File: tb/tb_lane_obj_gen.sv
module tb_lane_obj_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x, y;
    logic        refresh_tick;
    logic        run;
    logic [14:0] lane_speed;
    logic [4:0]  lane_dir;
    logic [9:0]  x_frog_l, y_frog_t;
    logic        obj_on;
    logic [2:0]  obj_lane;
    logic [6:0]  obj_col;
    logic [4:0]  obj_row;
    logic        hit;
`ifdef LANE_CARRY_EN
    logic              carry_valid;
    logic signed [3:0] carry_dx;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    lane_obj_gen dut (
        .clk          (clk),
        .reset        (reset),
        .x            (x),
        .y            (y),
        .refresh_tick (refresh_tick),
        .run          (run),
        .lane_speed   (lane_speed),
        .lane_dir     (lane_dir),
        .x_frog_l     (x_frog_l),
        .y_frog_t     (y_frog_t),
        .obj_on       (obj_on),
        .obj_lane     (obj_lane),
        .obj_col      (obj_col),
        .obj_row      (obj_row),
        .hit          (hit)
`ifdef LANE_CARRY_EN
        ,
        .carry_valid  (carry_valid),
        .carry_dx     (carry_dx)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one pixel, then check the registered result one clock later.
    task automatic px(input int px_x, input int px_y, input logic e_on,
                      input int e_lane, input int e_col, input int e_row);
        string t;
        @(negedge clk);
        x = 10'(px_x);
        y = 10'(px_y);
        @(negedge clk);
        t = $sformatf("(%0d,%0d)", px_x, px_y);
        chk({t, " obj_on"},   32'(obj_on),   32'(e_on));
        chk({t, " obj_lane"}, 32'(obj_lane), 32'(e_lane));
        chk({t, " obj_col"},  32'(obj_col),  32'(e_col));
        chk({t, " obj_row"},  32'(obj_row),  32'(e_row));
    endtask

    // One frame tick with the pixel at (tx,ty) during the tick clock.
    task automatic tick_at(input int tx, input int ty);
        @(negedge clk);
        x = 10'(tx);
        y = 10'(ty);
        refresh_tick = 1'b1;
        @(negedge clk);
        refresh_tick = 1'b0;
        x = 10'd0;
        y = 10'd481;
    endtask

    task automatic tick();
        tick_at(0, 481);
    endtask

    initial begin
        reset        = 1'b1;
        x            = 10'd0;
        y            = 10'd0;
        refresh_tick = 1'b0;
        run          = 1'b0;
        lane_speed   = '0;
        lane_dir     = '0;
        x_frog_l     = 10'd900;
        y_frog_t     = 10'd900;
        repeat (3) @(negedge clk);
        chk("rst obj_on",   32'(obj_on),   32'd0);
        chk("rst obj_lane", 32'(obj_lane), 32'd0);
        chk("rst obj_col",  32'(obj_col),  32'd0);
        chk("rst obj_row",  32'(obj_row),  32'd0);
        chk("rst hit",      32'(hit),      32'd0);
        reset = 1'b0;

        // Reset phases: off[l] = 32*l
        px( 64, 324, 1, 2,  0,  0);
        px(127, 324, 1, 2, 63,  0);
        px( 63, 324, 0, 0,  0,  0);
        px(128, 324, 0, 0,  0,  0);
        px(192, 324, 1, 2,  0,  0);
        px(  0, 260, 1, 0,  0,  0);
        px(  0, 259, 0, 0,  0,  0);
        px( 10, 419, 1, 4, 10, 31);
        px( 10, 420, 0, 0,  0,  0);
        px(650, 260, 0, 0,  0,  0);
        px(639, 356, 1, 3, 31,  0);
        px(  0, 356, 1, 3, 32,  0);

        // Lane 0 right at 3 px/frame for 43 frames: off[0] = 129 mod 128 = 1
        lane_speed = 15'd3;
        lane_dir   = 5'b00000;
        run        = 1'b1;
        repeat (43) tick();
        px(  0, 260, 0, 0,  0, 0);
        px(  1, 260, 1, 0,  0, 0);
        px( 64, 260, 1, 0, 63, 0);
        px( 64, 324, 1, 2,  0, 0);

        // Lane 1 left at 4 px/frame for 9 frames: off[1] = 32-36 mod 128 = 124
        lane_speed = 15'(4 << 3);
        lane_dir   = 5'b00010;
        repeat (9) tick();
        px(124, 292, 1, 1,  0, 0);
        px(123, 292, 0, 0,  0, 0);
        px(187, 292, 1, 1, 63, 0);
        px(188, 292, 0, 0,  0, 0);
        run = 1'b0;
        repeat (5) tick();
        px(124, 292, 1, 1,  0, 0);
        px(  1, 260, 1, 0,  0, 0);

        // Collision
        chk("hit idle", 32'(hit), 32'd0);
        x_frog_l = 10'd100;
        y_frog_t = 10'd300;
        px(110, 300, 0, 0, 0, 0);
        tick();
        chk("hit frog on gap", 32'(hit), 32'd0);
        px(125, 300, 1, 1, 1, 8);
        chk("hit before tick", 32'(hit), 32'd0);
        tick();
        chk("hit after tick", 32'(hit), 32'd1);
        x_frog_l = 10'd900;
        y_frog_t = 10'd900;
        px(125, 300, 1, 1, 1, 8);
        tick();
        chk("hit cleared", 32'(hit), 32'd0);
        x_frog_l = 10'd100;
        y_frog_t = 10'd300;
        tick_at(125, 300);
        chk("hit term on tick clk", 32'(hit), 32'd1);
        tick();
        chk("hit acc cleared by tick", 32'(hit), 32'd0);

        // Asynchronous reset mid-frame
        tick_at(125, 300);
        chk("hit before reset", 32'(hit), 32'd1);
        px(1, 270, 1, 0, 0, 10);
        #2;
        reset = 1'b1;
        #1;
        chk("async rst hit",    32'(hit),    32'd0);
        chk("async rst obj_on", 32'(obj_on), 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        x_frog_l = 10'd900;
        y_frog_t = 10'd900;
        px( 32, 292, 1, 1, 0, 0);
        px(  0, 260, 1, 0, 0, 0);
        px( 64, 324, 1, 2, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
